// File: rtl/cache_ctrl_pkg.sv
// Shared types and op-mask constants for the cache maintenance sequencer.
package cache_ctrl_pkg;

    typedef struct packed {
        logic iclear;
        logic iflush;
        logic dclear;
        logic dflush;
    } cache_op_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DFLUSH = 3'd1,
        ST_DCLEAR = 3'd2,
        ST_IFLUSH = 3'd3,
        ST_ICLEAR = 3'd4,
        ST_DONE   = 3'd5
    } seq_state_t;

    localparam logic [3:0] OP_FENCE_I   = 4'b1001;
    localparam logic [3:0] OP_FLUSH_ALL = 4'b0101;
    localparam logic [3:0] OP_CLEAR_ALL = 4'b1010;

endpackage

// File: rtl/cache_ctrl_watchdog.sv
// Per-step saturating timer; flags expiry on the cycle the count would reach
// TIMEOUT_CYCLES. TIMEOUT_CYCLES = 0 disables expiry entirely.
module cache_ctrl_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic CLK,
    input  logic nRST,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] SAT_VAL  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST_VAL = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en && (r_count != SAT_VAL)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // The cycle holding count TIMEOUT-1 is the last one a step may occupy.
    assign o_expired = (TIMEOUT_CYCLES > 0) && i_en && (r_count >= LAST_VAL);

endmodule

// File: rtl/cache_control_sequencer.sv
// Runs cache maintenance steps for one op mask in the order DFLUSH, DCLEAR,
// IFLUSH, ICLEAR, waiting on each done, with a per-step watchdog.
//   state  | meaning
//   IDLE   | ready for a request
//   DFLUSH | dcache_flush high, waiting for dflush_done
//   DCLEAR | dcache_clear high, waiting for dclear_done
//   IFLUSH | icache_flush high, waiting for iflush_done
//   ICLEAR | icache_clear high, waiting for iclear_done
//   DONE   | one-cycle seq_done (and seq_error on timeout)
module cache_control_sequencer
    import cache_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       req_valid,
    input  logic [3:0] req_op,
    output logic       req_ready,
    output logic       busy,
    output logic       seq_done,
    output logic       seq_error,
    output logic       icache_clear,
    output logic       icache_flush,
    output logic       dcache_clear,
    output logic       dcache_flush,
    input  logic       iclear_done,
    input  logic       iflush_done,
    input  logic       dclear_done,
    input  logic       dflush_done
);

    seq_state_t r_state;
    seq_state_t w_state_nxt;
    cache_op_t  r_mask;
    cache_op_t  w_mask_nxt;
    cache_op_t  r_cmd;
    cache_op_t  w_cmd_nxt;
    cache_op_t  w_cur_bit;
    cache_op_t  w_remaining;
    logic       r_seq_done;
    logic       r_seq_error;
    logic       w_error_nxt;
    logic       w_step_done;
    logic       w_in_step;
    logic       w_wd_clear;
    logic       w_wd_expired;

    // dflush ranks first so fence.i writes back dirty lines before invalidation.
    function automatic seq_state_t first_step(input cache_op_t m);
        if (m.dflush)      return ST_DFLUSH;
        else if (m.dclear) return ST_DCLEAR;
        else if (m.iflush) return ST_IFLUSH;
        else if (m.iclear) return ST_ICLEAR;
        else               return ST_DONE;
    endfunction

    always_comb begin
        w_cur_bit   = '0;
        w_step_done = 1'b0;
        w_in_step   = 1'b1;
        case (r_state)
            ST_DFLUSH: begin w_cur_bit.dflush = 1'b1; w_step_done = dflush_done; end
            ST_DCLEAR: begin w_cur_bit.dclear = 1'b1; w_step_done = dclear_done; end
            ST_IFLUSH: begin w_cur_bit.iflush = 1'b1; w_step_done = iflush_done; end
            ST_ICLEAR: begin w_cur_bit.iclear = 1'b1; w_step_done = iclear_done; end
            default:   w_in_step = 1'b0;
        endcase
        w_remaining = r_mask & ~w_cur_bit;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mask_nxt  = r_mask;
        w_error_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_mask_nxt  = cache_op_t'(req_op);
                    w_state_nxt = first_step(cache_op_t'(req_op));
                end
            end
            ST_DFLUSH, ST_DCLEAR, ST_IFLUSH, ST_ICLEAR: begin
                if (w_step_done) begin
                    w_mask_nxt  = w_remaining;
                    w_state_nxt = first_step(w_remaining);
                end else if (w_wd_expired) begin
                    w_mask_nxt  = '0;
                    w_state_nxt = ST_DONE;
                    w_error_nxt = 1'b1;
                end
            end
            ST_DONE: begin
                w_mask_nxt  = '0;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_mask_nxt  = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_cmd_nxt = '0;
        case (w_state_nxt)
            ST_DFLUSH: w_cmd_nxt.dflush = 1'b1;
            ST_DCLEAR: w_cmd_nxt.dclear = 1'b1;
            ST_IFLUSH: w_cmd_nxt.iflush = 1'b1;
            ST_ICLEAR: w_cmd_nxt.iclear = 1'b1;
            default:   w_cmd_nxt = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state     <= ST_IDLE;
            r_mask      <= '0;
            r_cmd       <= '0;
            r_seq_done  <= 1'b0;
            r_seq_error <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_mask      <= w_mask_nxt;
            r_cmd       <= w_cmd_nxt;
            r_seq_done  <= (w_state_nxt == ST_DONE);
            r_seq_error <= w_error_nxt;
        end
    end

    // Any state change restarts the timer, which covers every step entry.
    assign w_wd_clear = (w_state_nxt != r_state);

    cache_ctrl_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .CLK       (CLK),
        .nRST      (nRST),
        .i_clear   (w_wd_clear),
        .i_en      (w_in_step),
        .o_expired (w_wd_expired)
    );

    assign req_ready    = (r_state == ST_IDLE);
    assign busy         = ~req_ready;
    assign seq_done     = r_seq_done;
    assign seq_error    = r_seq_error;
    assign icache_clear = r_cmd.iclear;
    assign icache_flush = r_cmd.iflush;
    assign dcache_clear = r_cmd.dclear;
    assign dcache_flush = r_cmd.dflush;

endmodule

// File: tb/tb_cache_control_sequencer.sv
// Directed bench for cache_control_sequencer with an 8-cycle watchdog.
module tb_cache_control_sequencer;
    import cache_ctrl_pkg::*;

    logic       CLK = 1'b0;
    logic       nRST = 1'b0;
    logic       req_valid = 1'b0;
    logic [3:0] req_op = 4'b0000;
    logic       req_ready, busy, seq_done, seq_error;
    logic       icache_clear, icache_flush, dcache_clear, dcache_flush;
    logic       iclear_done = 1'b0;
    logic       iflush_done = 1'b0;
    logic       dclear_done = 1'b0;
    logic       dflush_done = 1'b0;
    logic [3:0] cmd;

    int n_vec = 0;
    int n_err = 0;

    cache_control_sequencer #(.TIMEOUT_CYCLES(8)) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .req_valid    (req_valid),
        .req_op       (req_op),
        .req_ready    (req_ready),
        .busy         (busy),
        .seq_done     (seq_done),
        .seq_error    (seq_error),
        .icache_clear (icache_clear),
        .icache_flush (icache_flush),
        .dcache_clear (dcache_clear),
        .dcache_flush (dcache_flush),
        .iclear_done  (iclear_done),
        .iflush_done  (iflush_done),
        .dclear_done  (dclear_done),
        .dflush_done  (dflush_done)
    );

    always #5 CLK = ~CLK;

    // {iclear, iflush, dclear, dflush}
    assign cmd = {icache_clear, icache_flush, dcache_clear, dcache_flush};

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Inputs change at negedge; one tick crosses one rising edge and lands on the next negedge.
    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Outputs expected while a step holds the given command.
    task automatic chk_step(input string tag, input logic [3:0] exp_cmd);
        chk({tag, "_cmd"}, {4'b0, cmd}, {4'b0, exp_cmd});
        chk({tag, "_busy"}, {7'b0, busy}, 8'd1);
        chk({tag, "_done"}, {7'b0, seq_done}, 8'd0);
    endtask

    initial begin
        #2;
        chk("rst_ready", {7'b0, req_ready}, 8'd1);
        chk("rst_busy", {7'b0, busy}, 8'd0);
        chk("rst_cmd", {4'b0, cmd}, 8'h00);
        chk("rst_done", {7'b0, seq_done}, 8'd0);
        chk("rst_err", {7'b0, seq_error}, 8'd0);
        @(negedge CLK);
        nRST = 1'b1;
        tick();
        chk("idle_ready", {7'b0, req_ready}, 8'd1);

        // fence.i: dflush done after 5 cycles, iclear done after 3
        req_valid = 1'b1; req_op = OP_FENCE_I;
        tick();
        req_valid = 1'b0;
        chk("fi_ready", {7'b0, req_ready}, 8'd0);
        for (int i = 1; i <= 5; i++) begin
            chk_step($sformatf("fi_df%0d", i), 4'b0001);
            if (i == 5) dflush_done = 1'b1;
            tick();
        end
        dflush_done = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            chk_step($sformatf("fi_ic%0d", i), 4'b1000);
            if (i == 3) iclear_done = 1'b1;
            tick();
        end
        iclear_done = 1'b0;
        chk("fi_seqdone", {7'b0, seq_done}, 8'd1);
        chk("fi_seqerr", {7'b0, seq_error}, 8'd0);
        chk("fi_done_cmd", {4'b0, cmd}, 8'h00);
        chk("fi_done_ready", {7'b0, req_ready}, 8'd0);
        tick();
        chk("fi_idle_done", {7'b0, seq_done}, 8'd0);
        chk("fi_idle_ready", {7'b0, req_ready}, 8'd1);

        // full mask with every done already high
        req_valid = 1'b1; req_op = 4'b1111;
        dflush_done = 1'b1; dclear_done = 1'b1; iflush_done = 1'b1; iclear_done = 1'b1;
        tick();
        req_valid = 1'b0;
        chk_step("full_df", 4'b0001);
        tick();
        chk_step("full_dc", 4'b0010);
        tick();
        chk_step("full_if", 4'b0100);
        tick();
        chk_step("full_ic", 4'b1000);
        tick();
        chk("full_seqdone", {7'b0, seq_done}, 8'd1);
        chk("full_seqerr", {7'b0, seq_error}, 8'd0);
        chk("full_done_cmd", {4'b0, cmd}, 8'h00);
        dflush_done = 1'b0; dclear_done = 1'b0; iflush_done = 1'b0; iclear_done = 1'b0;
        tick();
        chk("full_idle", {7'b0, req_ready}, 8'd1);

        // empty op goes straight to DONE
        req_valid = 1'b1; req_op = 4'b0000;
        tick();
        req_valid = 1'b0;
        chk("empty_seqdone", {7'b0, seq_done}, 8'd1);
        chk("empty_cmd", {4'b0, cmd}, 8'h00);
        chk("empty_seqerr", {7'b0, seq_error}, 8'd0);
        tick();
        chk("empty_idle", {7'b0, req_ready}, 8'd1);
        chk("empty_done_low", {7'b0, seq_done}, 8'd0);

        // timeout: dflush never completes, dclear must be skipped
        req_valid = 1'b1; req_op = 4'b0011;
        tick();
        req_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            chk_step($sformatf("to_df%0d", i), 4'b0001);
            tick();
        end
        chk("to_seqdone", {7'b0, seq_done}, 8'd1);
        chk("to_seqerr", {7'b0, seq_error}, 8'd1);
        chk("to_cmd", {4'b0, cmd}, 8'h00);
        tick();
        chk("to_idle", {7'b0, req_ready}, 8'd1);
        chk("to_err_low", {7'b0, seq_error}, 8'd0);

        // stray dones and a request held while busy
        req_valid = 1'b1; req_op = OP_FLUSH_ALL;
        tick();
        req_op = OP_CLEAR_ALL;
        chk_step("st_df1", 4'b0001);
        iclear_done = 1'b1; dclear_done = 1'b1;
        tick();
        iclear_done = 1'b0; dclear_done = 1'b0;
        chk_step("st_df2", 4'b0001);
        dflush_done = 1'b1;
        tick();
        dflush_done = 1'b0;
        chk_step("st_if", 4'b0100);
        iflush_done = 1'b1;
        tick();
        iflush_done = 1'b0;
        chk("st_seqdone", {7'b0, seq_done}, 8'd1);
        chk("st_done_ready", {7'b0, req_ready}, 8'd0);
        tick();
        chk("st_idle_ready", {7'b0, req_ready}, 8'd1);
        chk("st_idle_cmd", {4'b0, cmd}, 8'h00);
        tick();
        req_valid = 1'b0;
        chk_step("st_held_dc", 4'b0010);
        dclear_done = 1'b1;
        tick();
        dclear_done = 1'b0;
        chk_step("st_held_ic", 4'b1000);
        iclear_done = 1'b1;
        tick();
        iclear_done = 1'b0;
        chk("st_held_seqdone", {7'b0, seq_done}, 8'd1);
        tick();

        // reset asserted mid-DFLUSH
        req_valid = 1'b1; req_op = OP_FENCE_I;
        tick();
        req_valid = 1'b0;
        tick();
        chk_step("mr_df", 4'b0001);
        #2 nRST = 1'b0;
        #1;
        chk("mr_dflush", {7'b0, dcache_flush}, 8'd0);
        chk("mr_ready", {7'b0, req_ready}, 8'd1);
        chk("mr_done", {7'b0, seq_done}, 8'd0);
        #1 nRST = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("mr_after%0d_done", i), {7'b0, seq_done}, 8'd0);
            chk($sformatf("mr_after%0d_cmd", i), {4'b0, cmd}, 8'h00);
            chk($sformatf("mr_after%0d_ready", i), {7'b0, req_ready}, 8'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
